// File: rtl/frame_text_reader.sv
// rtl/frame_text_reader.sv - per-frame shadowed time/date/timer text lookup with blinking cursor
module frame_text_reader #(
   parameter int BLINK_FRAMES = 30,
   parameter int COL0         = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [71:0] digits_in,
   input  logic        AM_PM,
   input  logic [2:0]  dia_semana,
   input  logic [1:0]  funcion,
   input  logic [1:0]  cursor_location,
   input  logic        frame_start,
   input  logic        char_req,
   input  logic [6:0]  char_col,
   input  logic [4:0]  char_row,
   output logic [6:0]  char_code,
   output logic        cursor_on,
   output logic        char_valid
);

   localparam logic [7:0] BlinkLast = 8'(BLINK_FRAMES - 1);
   localparam logic [7:0] Col0B     = 8'(COL0);
   localparam logic [6:0] Space     = 7'h20;

   // Nibbles above 9 are not BCD and render as '?'
   function automatic logic [6:0] bcd_ascii(input logic [3:0] n);
      return (n > 4'd9) ? 7'h3F : (7'h30 + {3'b000, n});
   endfunction

   logic [71:0] digits_q;
   logic        am_pm_q;
   logic [2:0]  dia_q;
   logic [1:0]  funcion_q;
   logic [1:0]  cursor_loc_q;
   logic [7:0]  blink_cnt_q;
   logic        blink_phase_q;
   logic        s1_valid_q;
   logic [6:0]  s1_code_q;
   logic        s1_cursor_q;
   logic        out_valid_q;
   logic [6:0]  out_code_q;
   logic        out_cursor_q;

   logic [7:0]  c_rel;
   logic [23:0] trio;
   logic [6:0]  sep;
   logic [20:0] wd_str;
   logic [7:0]  sel_col;
   logic        sel_ok;
   logic        field_row;
   logic [6:0]  code_d;
   logic        cursor_d;

   // Signed column offset; bit 7 set means the cell lies left of the fields
   assign c_rel = {1'b0, char_col} - Col0B;

   // Shadow copy of the producer fields, refreshed only at the frame boundary
   always_ff @(posedge clk) begin
      if (reset) begin
         digits_q     <= '0;
         am_pm_q      <= 1'b0;
         dia_q        <= '0;
         funcion_q    <= '0;
         cursor_loc_q <= '0;
      end else if (frame_start) begin
         digits_q     <= digits_in;
         am_pm_q      <= AM_PM;
         dia_q        <= dia_semana;
         funcion_q    <= funcion;
         cursor_loc_q <= cursor_location;
      end
   end

   // Frame counter toggling the cursor phase every BLINK_FRAMES frames
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
      end else if (frame_start) begin
         if (blink_cnt_q == BlinkLast) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 8'd1;
         end
      end
   end

   // Pick the digit trio and separator for the addressed field row
   always_comb begin
      trio = digits_q[23:0];
      sep  = 7'h3A;
      case (char_row)
         5'd4: begin
            trio = digits_q[47:24];
            sep  = 7'h2F;
         end
         5'd8:    trio = digits_q[71:48];
         default: ;
      endcase
   end

   // Three-letter weekday name, first letter in the top bits
   always_comb begin
      case (dia_q)
         3'd0:    wd_str = {7'h4C, 7'h55, 7'h4E};
         3'd1:    wd_str = {7'h4D, 7'h41, 7'h52};
         3'd2:    wd_str = {7'h4D, 7'h49, 7'h45};
         3'd3:    wd_str = {7'h4A, 7'h55, 7'h45};
         3'd4:    wd_str = {7'h56, 7'h49, 7'h45};
         3'd5:    wd_str = {7'h53, 7'h41, 7'h42};
         3'd6:    wd_str = {7'h44, 7'h4F, 7'h4D};
         default: wd_str = {7'h2D, 7'h2D, 7'h2D};
      endcase
   end

   // Which row/field the cursor is allowed to sit on
   always_comb begin
      field_row = ((funcion_q == 2'd1) && (char_row == 5'd2)) ||
                  ((funcion_q == 2'd2) && (char_row == 5'd4)) ||
                  ((funcion_q == 2'd3) && (char_row == 5'd8));
      sel_ok  = 1'b1;
      sel_col = 8'd0;
      case (cursor_loc_q)
         2'd2:    sel_col = 8'd0;
         2'd1:    sel_col = 8'd3;
         2'd0:    sel_col = 8'd6;
         default: sel_ok  = 1'b0;
      endcase
   end

   // Cell lookup against the shadow as it stands in the request cycle
   always_comb begin
      code_d   = Space;
      cursor_d = 1'b0;
      if (!c_rel[7]) begin
         if ((char_row == 5'd2) || (char_row == 5'd4) || (char_row == 5'd8)) begin
            case (c_rel)
               8'd0:       code_d = bcd_ascii(trio[7:4]);
               8'd1:       code_d = bcd_ascii(trio[3:0]);
               8'd3:       code_d = bcd_ascii(trio[15:12]);
               8'd4:       code_d = bcd_ascii(trio[11:8]);
               8'd6:       code_d = bcd_ascii(trio[23:20]);
               8'd7:       code_d = bcd_ascii(trio[19:16]);
               8'd2, 8'd5: code_d = sep;
               8'd9:  if (char_row == 5'd2) code_d = am_pm_q ? 7'h50 : 7'h41;
               8'd10: if (char_row == 5'd2) code_d = 7'h4D;
               default: ;
            endcase
            if (blink_phase_q && field_row && sel_ok &&
                ((c_rel == sel_col) || (c_rel == sel_col + 8'd1)))
               cursor_d = 1'b1;
         end else if (char_row == 5'd6) begin
            case (c_rel)
               8'd0:    code_d = wd_str[20:14];
               8'd1:    code_d = wd_str[13:7];
               8'd2:    code_d = wd_str[6:0];
               default: ;
            endcase
         end
      end
   end

   // Two-stage result pipeline; reset drops anything in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q   <= 1'b0;
         s1_code_q    <= Space;
         s1_cursor_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_code_q   <= Space;
         out_cursor_q <= 1'b0;
      end else begin
         s1_valid_q   <= char_req;
         s1_code_q    <= char_req ? code_d : Space;
         s1_cursor_q  <= char_req & cursor_d;
         out_valid_q  <= s1_valid_q;
         out_code_q   <= s1_code_q;
         out_cursor_q <= s1_cursor_q;
      end
   end

   assign char_valid = out_valid_q;
   assign char_code  = out_code_q;
   assign cursor_on  = out_cursor_q;

endmodule

// File: tb/tb_frame_text_reader.sv
// tb/tb_frame_text_reader.sv - scoreboard bench for frame_text_reader against a text-layout model
module tb_frame_text_reader;

   localparam int BLINK = 2;
   localparam int COL0  = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [71:0] digits_in = '0;
   logic        AM_PM = 1'b0;
   logic [2:0]  dia_semana = '0;
   logic [1:0]  funcion = '0;
   logic [1:0]  cursor_location = '0;
   logic        frame_start = 1'b0;
   logic        char_req = 1'b0;
   logic [6:0]  char_col = '0;
   logic [4:0]  char_row = '0;
   logic [6:0]  char_code;
   logic        cursor_on;
   logic        char_valid;

   frame_text_reader #(.BLINK_FRAMES(BLINK), .COL0(COL0)) dut (
      .clk(clk), .reset(reset), .digits_in(digits_in), .AM_PM(AM_PM),
      .dia_semana(dia_semana), .funcion(funcion), .cursor_location(cursor_location),
      .frame_start(frame_start), .char_req(char_req), .char_col(char_col),
      .char_row(char_row), .char_code(char_code), .cursor_on(cursor_on),
      .char_valid(char_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [6:0] code;
      logic       cur;
      int         due;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   bit   mon_en = 1'b0;

   logic [71:0] m_digits;
   bit          m_ampm;
   int          m_dia, m_fun, m_loc, m_frames;
   string       wd_names[8] = '{"LUN", "MAR", "MIE", "JUE", "VIE", "SAB", "DOM", "---"};

   function automatic byte dch(input int v);
      return (v < 10) ? byte'(8'h30 + v) : 8'h3F;
   endfunction

   function automatic int nib(input int i);
      return int'(m_digits[4*i +: 4]);
   endfunction

   task automatic model_reset();
      m_digits = '0; m_ampm = 0; m_dia = 0; m_fun = 0; m_loc = 0; m_frames = 0;
   endtask

   task automatic model_frame();
      m_digits = digits_in; m_ampm = AM_PM; m_dia = int'(dia_semana);
      m_fun = int'(funcion); m_loc = int'(cursor_location);
      m_frames++;
   endtask

   // Render the whole row as text, then index the requested cell
   task automatic model_cell(input int row, input int col, output logic [6:0] code, output logic cur);
      byte t[11];
      byte b;
      int  c, base, f, frow;
      bit  phase;
      foreach (t[i]) t[i] = 8'h20;
      c = col - COL0;
      if (row == 2 || row == 4 || row == 8) begin
         base = (row == 2) ? 0 : (row == 4) ? 3 : 6;
         for (int k = 0; k < 3; k++) begin
            t[3*k]   = dch(nib(2*(base+k)+1));
            t[3*k+1] = dch(nib(2*(base+k)));
         end
         t[2] = (row == 4) ? 8'h2F : 8'h3A;
         t[5] = t[2];
         if (row == 2) begin
            t[9]  = m_ampm ? 8'h50 : 8'h41;
            t[10] = 8'h4D;
         end
      end else if (row == 6) begin
         for (int k = 0; k < 3; k++) t[k] = wd_names[m_dia][k];
      end
      b = (c >= 0 && c < 11) ? t[c] : 8'h20;
      code = b[6:0];
      phase = (((m_frames / BLINK) % 2) == 0);
      frow = (m_fun == 1) ? 2 : (m_fun == 2) ? 4 : (m_fun == 3) ? 8 : -1;
      f = 2 - m_loc;
      cur = phase && m_fun != 0 && m_loc != 3 && row == frow && (c == 3*f || c == 3*f + 1);
   endtask

   task automatic step(input bit req, input int row, input int col, input bit fs);
      exp_t e;
      char_req = req; char_row = 5'(row); char_col = 7'(col); frame_start = fs;
      if (req) begin
         model_cell(row, col, e.code, e.cur);
         e.due = cyc + 2;
         sb.push_back(e);
      end
      if (fs) model_frame();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            n_vec++;
            if (sb.size() >= 0 && (mon_e.due != cyc || !char_valid ||
                char_code !== mon_e.code || cursor_on !== mon_e.cur)) begin
               n_miss++;
               $display("FAIL lookup @%0d: valid=%0b code=%h cur=%0b, expected valid=1 code=%h cur=%0b",
                        cyc, char_valid, char_code, cursor_on, mon_e.code, mon_e.cur);
            end
         end else if (char_valid) begin
            n_vec++;
            n_miss++;
            $display("FAIL spurious_valid @%0d: valid=1 code=%h, expected valid=0", cyc, char_code);
         end
      end
   end

   initial begin
      int r;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
      chk("reset_valid", int'(char_valid), 0);
      chk("reset_code", int'(char_code), 'h20);
      chk("reset_cursor", int'(cursor_on), 0);
      mon_en = 1'b1;

      step(1, 2, 4, 0);
      repeat (3) step(0, 0, 0, 0);

      digits_in = '0;
      digits_in[23:0] = 24'h39_52_15;
      AM_PM = 1'b1;
      step(0, 0, 0, 1);
      for (int col = 4; col <= 14; col++) step(1, 2, col, 0);

      digits_in = 72'({$urandom(), $urandom(), $urandom()});
      for (int col = 4; col <= 11; col++) step(1, 2, col, 0);
      step(1, 2, 5, 1);
      step(1, 2, 5, 0);

      funcion = 2'd2; cursor_location = 2'd2;
      step(0, 0, 0, 1);
      for (int n = 0; n < 6; n++) begin
         for (int col = 4; col <= 6; col++) step(1, 4, col, 0);
         step(0, 0, 0, 1);
      end

      for (int d = 0; d < 8; d++) begin
         dia_semana = 3'(d);
         step(0, 0, 0, 1);
         for (int col = 4; col <= 6; col++) step(1, 6, col, 0);
      end
      digits_in[43:40] = 4'hB;
      step(0, 0, 0, 1);
      step(1, 4, 11, 0);
      step(1, 4, 3, 0);

      for (int n = 0; n < 3000; n++) begin
         if (n % 16 == 0) begin
            digits_in = 72'({$urandom(), $urandom(), $urandom()});
            AM_PM = 1'($urandom());
            dia_semana = 3'($urandom());
            funcion = 2'($urandom());
            cursor_location = 2'($urandom());
         end
         r = $urandom_range(0, 7);
         step(1'($urandom_range(0, 3) != 0),
              (r < 6) ? 2 * $urandom_range(1, 4) : $urandom_range(0, 29),
              (r < 5) ? $urandom_range(0, 16) : $urandom_range(0, 79),
              $urandom_range(0, 7) == 0);
      end
      repeat (3) step(0, 0, 0, 0);

      digits_in = 72'({$urandom(), $urandom(), $urandom()});
      step(1, 2, 4, 0);
      reset = 1'b1; char_req = 1'b1; char_row = 5'd2; char_col = 7'd5; frame_start = 1'b0;
      sb.delete();
      @(negedge clk);
      reset = 1'b0; char_req = 1'b0;
      model_reset();
      repeat (3) step(0, 0, 0, 0);
      for (int col = 4; col <= 14; col++) step(1, 2, col, 0);
      for (int col = 4; col <= 6; col++) step(1, 6, col, 0);
      funcion = 2'd1; cursor_location = 2'd0;
      step(0, 0, 0, 1);
      for (int col = 9; col <= 12; col++) step(1, 2, col, 0);

      for (int n = 0; n < 10 && sb.size() > 0; n++) step(0, 0, 0, 0);
      if (sb.size() != 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
